// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: round robin between CPU (m0) and loader (m1), with bounded m1 lock.
// Latency: grant is combinational (zero-cycle accept); read data/rvalid return one cycle after the grant.
// Backpressure: a master that is not granted holds req/we/addr/wdata until granted; there is no response backpressure.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   m0_* / m1_*                     - per-master request (req, we, addr, wdata), accept (gnt), read return (rvalid, rdata)
//   m1_lock                         - master 1 asks for consecutive ownership (at most MAX_LOCK transfers in a row)
//   mem_we, mem_addr, mem_wdata     - memory drive from the granted master (all zero when nothing is granted)
//   mem_rdata                       - combinational memory read data for mem_addr
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    // Count value at which the next locked grant is the MAX_LOCK-th consecutive
    // master-1 transfer (the grant that entered the lock counts as the first).
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state;
    logic             last;       // last granted master: 0 = m0, 1 = m1
    logic [CNT_W-1:0] lock_cnt;   // master-1 transfers made under the current lock

    // Grant decode. Both grants are held low while reset is asserted.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            if (state == LOCK) begin
                m1_gnt = m1_req;
            end else if (m0_req && m1_req) begin
                // Contention: the master that did not win last time goes first.
                m0_gnt = last;
                m1_gnt = ~last;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // Memory drive from the winner; idle bus is all zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Arbitration state: round-robin pointer and lock FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else begin
            if (m0_gnt) begin
                last <= 1'b0;
            end else if (m1_gnt) begin
                last <= 1'b1;
            end

            case (state)
                ARB: begin
                    // With MAX_LOCK of 1 the locking grant is already the last
                    // allowed one, so the lock is never actually entered.
                    if (m1_gnt && m1_lock && (MAX_LOCK > 1)) begin
                        state    <= LOCK;
                        lock_cnt <= CNT_W'(1);
                    end
                end
                LOCK: begin
                    if (!m1_lock) begin
                        state    <= ARB;
                        lock_cnt <= '0;
                    end else if (m1_gnt) begin
                        if (lock_cnt == LOCK_LAST) begin
                            // Forced release: m1 is marked as last winner so a
                            // waiting m0 is served before m1 can lock again.
                            state    <= ARB;
                            lock_cnt <= '0;
                            last     <= 1'b1;
                        end else begin
                            lock_cnt <= lock_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= ARB;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    // Read return: capture the memory data on an accepted read; rvalid pulses
    // for one cycle, rdata holds until that master's next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rdata <= mem_rdata;
            end
            if (m1_gnt && !m1_we) begin
                m1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: vector table, hand-written reset/lock sequences, random traffic vs reference model.
// Latency: checks combinational grants and memory drive mid-cycle, read returns one cycle after the grant.
// Backpressure: none modelled beyond the grant itself; the memory is an ideal combinational array.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Ideal single-ported memory: 16 words, word index from addr[5:2].
    logic [DW-1:0] mem [16];
    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks who won most recently, whether m1 currently owns the memory, and
    // how many m1 transfers in a row have been made under that ownership.
    int            r_last;
    bit            r_owned;
    int            r_streak;
    logic [DW-1:0] ref_mem [16];
    bit            e_rv0, e_rv1;
    logic [DW-1:0] e_rd0, e_rd1;

    task automatic model_reset();
        r_last   = 1;
        r_owned  = 0;
        r_streak = 0;
        e_rv0 = 0; e_rv1 = 0;
        e_rd0 = '0; e_rd1 = '0;
    endtask

    // Captured actual values of the last cycle, for table/hand checks.
    logic s_g0, s_g1, s_rv1;
    logic [DW-1:0] s_rd1;

    // One clock cycle: inputs already driven (entered at posedge+1).
    task automatic cycle();
        bit pg0, pg1;
        logic          x_we;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd;
        if (r_owned) begin
            pg0 = 0; pg1 = m1_req;
        end else if (m0_req && m1_req) begin
            pg0 = (r_last == 1); pg1 = (r_last == 0);
        end else begin
            pg0 = m0_req; pg1 = m1_req;
        end
        x_we = 0; x_addr = '0; x_wd = '0;
        if (pg0) begin x_we = m0_we; x_addr = m0_addr; x_wd = m0_wdata; end
        if (pg1) begin x_we = m1_we; x_addr = m1_addr; x_wd = m1_wdata; end

        @(negedge clk);
        s_g0 = m0_gnt; s_g1 = m1_gnt; s_rv1 = m1_rvalid; s_rd1 = m1_rdata;
        chk("m0_gnt", m0_gnt, pg0);
        chk("m1_gnt", m1_gnt, pg1);
        chk("mem_we", mem_we, x_we);
        chk("mem_addr", mem_addr, x_addr);
        chk("mem_wdata", mem_wdata, x_wd);
        chk("m0_rvalid", m0_rvalid, e_rv0);
        chk("m1_rvalid", m1_rvalid, e_rv1);
        chk("m0_rdata", m0_rdata, e_rd0);
        chk("m1_rdata", m1_rdata, e_rd1);

        // Effects of the coming edge.
        e_rv0 = pg0 && !m0_we;
        e_rv1 = pg1 && !m1_we;
        if (e_rv0) e_rd0 = ref_mem[m0_addr[5:2]];
        if (e_rv1) e_rd1 = ref_mem[m1_addr[5:2]];
        if (pg0 && m0_we) ref_mem[m0_addr[5:2]] = m0_wdata;
        if (pg1 && m1_we) ref_mem[m1_addr[5:2]] = m1_wdata;
        if (r_owned) begin
            if (!m1_lock) r_owned = 0;
            else if (pg1) begin
                r_streak++;
                if (r_streak >= ML) r_owned = 0;
            end
        end else if (pg1 && m1_lock) begin
            r_streak = 1;
            r_owned  = (r_streak < ML);
        end
        if (pg0) r_last = 0;
        if (pg1) r_last = 1;

        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          m0_req, m0_we;
        logic [AW-1:0] m0_addr;
        logic [DW-1:0] m0_wdata;
        logic          m1_req, m1_we;
        logic [AW-1:0] m1_addr;
        logic          m1_lock;
        logic          eg0, eg1;
        logic          chk_rd1;
        logic [DW-1:0] erd1;
    } vec_t;

    function automatic vec_t mk(logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                logic r1, logic w1, logic [AW-1:0] a1, logic lk,
                                logic g0, logic g1);
        vec_t v;
        v.m0_req = r0; v.m0_we = w0; v.m0_addr = a0; v.m0_wdata = d0;
        v.m1_req = r1; v.m1_we = w1; v.m1_addr = a1; v.m1_lock = lk;
        v.eg0 = g0; v.eg1 = g1; v.chk_rd1 = 0; v.erd1 = '0;
        return v;
    endfunction

    vec_t tbl [20];

    task automatic drive(input vec_t v);
        m0_req = v.m0_req; m0_we = v.m0_we; m0_addr = v.m0_addr; m0_wdata = v.m0_wdata;
        m1_req = v.m1_req; m1_we = v.m1_we; m1_addr = v.m1_addr; m1_wdata = 32'hDEAD_0000;
        m1_lock = v.m1_lock;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'hA000_0000 + i;
            ref_mem[i] = 32'hA000_0000 + i;
        end
        // Round robin with both masters reading.
        tbl[0]  = mk(1, 0, 32'h10, 0,     1, 0, 32'h20, 0, 1, 0);
        tbl[1]  = mk(1, 0, 32'h10, 0,     1, 0, 32'h20, 0, 0, 1);
        tbl[2]  = mk(1, 0, 32'h10, 0,     1, 0, 32'h20, 0, 1, 0);
        tbl[3]  = mk(1, 0, 32'h10, 0,     1, 0, 32'h20, 0, 0, 1);
        // m0 writes 0x1E to 0x0, then m1 reads it back.
        tbl[4]  = mk(1, 1, 32'h0, 32'h1E, 0, 0, 32'h0,  0, 1, 0);
        tbl[5]  = mk(0, 0, 32'h0, 0,      1, 0, 32'h0,  0, 0, 1);
        // Bounded lock: m0 first (last=m1), then 4 locked m1 grants, m0, m1 re-locks.
        tbl[6]  = mk(1, 0, 32'h10, 0,     1, 0, 32'h20, 1, 1, 0);
        tbl[6].chk_rd1 = 1; tbl[6].erd1 = 32'h1E;
        tbl[7]  = mk(1, 0, 32'h10, 0,     1, 0, 32'h20, 1, 0, 1);
        tbl[8]  = mk(1, 0, 32'h10, 0,     1, 0, 32'h24, 1, 0, 1);
        tbl[9]  = mk(1, 0, 32'h10, 0,     1, 0, 32'h28, 1, 0, 1);
        tbl[10] = mk(1, 0, 32'h10, 0,     1, 0, 32'h2C, 1, 0, 1);
        tbl[11] = mk(1, 0, 32'h14, 0,     1, 0, 32'h30, 1, 1, 0);
        tbl[12] = mk(1, 0, 32'h14, 0,     1, 0, 32'h30, 1, 0, 1);
        // Early unlock: second locked grant, then lock drops while m0 waits.
        tbl[13] = mk(1, 0, 32'h14, 0,     1, 0, 32'h34, 1, 0, 1);
        tbl[14] = mk(1, 0, 32'h14, 0,     1, 0, 32'h38, 0, 0, 1);
        tbl[15] = mk(1, 0, 32'h14, 0,     1, 0, 32'h3C, 0, 1, 0);
        // Single master without lock, then idle.
        tbl[16] = mk(0, 0, 32'h0, 0,      1, 0, 32'h4,  0, 0, 1);
        tbl[17] = mk(0, 0, 32'h0, 0,      1, 0, 32'h8,  0, 0, 1);
        tbl[18] = mk(0, 0, 32'h0, 0,      0, 0, 32'h0,  0, 0, 0);
        tbl[19] = mk(0, 0, 32'h0, 0,      0, 0, 32'h0,  0, 0, 0);
    end

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
        model_reset();
        #2;
        chk("rst m0_rvalid", m0_rvalid, 0);
        chk("rst m1_rvalid", m1_rvalid, 0);
        chk("rst m0_rdata", m0_rdata, 0);
        chk("rst m1_rdata", m1_rdata, 0);
        chk("rst mem_we", mem_we, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i]);
            cycle();
            chk($sformatf("tbl[%0d] m0_gnt", i), s_g0, tbl[i].eg0);
            chk($sformatf("tbl[%0d] m1_gnt", i), s_g1, tbl[i].eg1);
            if (tbl[i].chk_rd1) begin
                chk($sformatf("tbl[%0d] m1_rvalid", i), s_rv1, 1);
                chk($sformatf("tbl[%0d] m1_rdata", i), s_rd1, tbl[i].erd1);
            end
        end

        // Reset in the middle of a locked read with both masters requesting.
        drive(mk(0, 0, 32'h0, 0, 1, 0, 32'h8, 1, 0, 1));
        cycle();
        drive(mk(1, 0, 32'h10, 0, 1, 0, 32'hC, 1, 0, 1));
        @(negedge clk);
        chk("pre-reset m1_gnt", m1_gnt, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-rst m0_gnt", m0_gnt, 0);
        chk("mid-rst m1_gnt", m1_gnt, 0);
        chk("mid-rst mem_we", mem_we, 0);
        chk("mid-rst mem_addr", mem_addr, 0);
        chk("mid-rst m1_rvalid", m1_rvalid, 0);
        chk("mid-rst m1_rdata", m1_rdata, 0);
        chk("mid-rst m0_rdata", m0_rdata, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        chk("post-rst first grant m0", s_g0, 1);
        chk("post-rst first grant m1", s_g1, 0);

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            m0_req   = ($urandom_range(0, 3) != 0);
            m0_we    = ($urandom_range(0, 2) == 0);
            m0_addr  = AW'({$urandom_range(0, 15), 2'b00});
            m0_wdata = $urandom;
            m1_req   = ($urandom_range(0, 3) != 0);
            m1_we    = ($urandom_range(0, 2) == 0);
            m1_addr  = AW'({$urandom_range(0, 15), 2'b00});
            m1_wdata = $urandom;
            m1_lock  = ($urandom_range(0, 4) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
